// File: rtl/iir_mc_pkg.sv
// Shared types and helpers for the multi-channel first-order IIR smoother.
// The pipeline record is sized for the widest supported build; narrower builds use the low bits.
package iir_mc_pkg;

   localparam int REC_DATA_W = 32;
   localparam int REC_COEF_W = 32;
   localparam int REC_CH_W   = 8;
   localparam int RS_W       = 128;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Adds half an LSB of the result, then floors: rounds half toward +inf.
   function automatic logic signed [RS_W-1:0] round_shift(input logic signed [RS_W-1:0] prod,
                                                          input int frac);
      logic signed [RS_W-1:0] half;
      half = '0;
      half[frac-1] = 1'b1;
      return (prod + half) >>> frac;
   endfunction

   // Power-up coefficient: alpha = 1/8.
   function automatic logic [REC_COEF_W-1:0] coef_reset(input int frac);
      logic [REC_COEF_W-1:0] v;
      v = '0;
      v[frac-3] = 1'b1;
      return v;
   endfunction

   typedef struct packed {
      logic                          valid;
      logic [REC_CH_W-1:0]           chan;
      logic signed [REC_DATA_W-1:0]  x;
      logic signed [REC_DATA_W-1:0]  yp;
      logic signed [REC_DATA_W:0]    diff;
      logic [REC_COEF_W-1:0]         coef;
      logic                          bypass;
   } s1_rec_t;

endpackage

// File: rtl/iir_mc_mac.sv
// Combinational update y = yp + round(diff * coef / 2^COEF_FRAC).
// Because alpha <= 1 the result lies between yp and x, so the final truncation is lossless.
module iir_mc_mac
   import iir_mc_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int COEF_FRAC = 15
) (
   input  logic signed [DATA_W:0]   diff_i,
   input  logic signed [DATA_W-1:0] yp_i,
   input  logic [COEF_W-1:0]        coef_i,
   output logic signed [DATA_W-1:0] y_o
);

   localparam int PROD_W = DATA_W + COEF_W + 2;

   logic signed [PROD_W-1:0] prod;
   logic signed [RS_W-1:0]   rounded;
   logic signed [DATA_W:0]   delta;
   logic signed [DATA_W:0]   y_wide;

   always_comb begin
      prod    = PROD_W'(diff_i) * PROD_W'($signed({1'b0, coef_i}));
      rounded = round_shift({{(RS_W-PROD_W){prod[PROD_W-1]}}, prod}, COEF_FRAC);
      delta   = rounded[DATA_W:0];
      y_wide  = (DATA_W+1)'(yp_i) + delta;
      y_o     = y_wide[DATA_W-1:0];
   end

endmodule

// File: rtl/iir_mc.sv
// Time-multiplexed multi-channel exponential smoother, two register stages, one sample per clock.
// Channel states live in flops so the asynchronous reset can clear them.
module iir_mc
   import iir_mc_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int CHANNELS  = 4,
   parameter int COEF_W    = 16,
   parameter int COEF_FRAC = 15,
   localparam int CH_W     = clog2_min1(CHANNELS)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     valid_i,
   input  logic [CH_W-1:0]          chan_i,
   input  logic signed [DATA_W-1:0] data_i,
   input  logic                     coef_we_i,
   input  logic [COEF_W-1:0]        coef_i,
   input  logic                     bypass_i,
   input  logic                     clear_i,
   output logic                     valid_o,
   output logic [CH_W-1:0]          chan_o,
   output logic signed [DATA_W-1:0] data_o
);

   localparam int CH_SLOTS = 1 << CH_W;
   localparam logic [COEF_W-1:0] COEF_ONE = COEF_W'(1) << COEF_FRAC;
   localparam logic [COEF_W-1:0] COEF_RST = COEF_W'(coef_reset(COEF_FRAC));

   logic signed [DATA_W-1:0] state_reg [CH_SLOTS];
   logic [COEF_W-1:0]        coef_reg;
   logic [COEF_W-1:0]        coef_next;
   s1_rec_t                  s1_reg;
   s1_rec_t                  s1_next;

   logic                     chan_ok;
   logic                     fwd_hit;
   logic signed [DATA_W-1:0] yp_rd;
   logic signed [DATA_W:0]   diff_next;
   logic signed [DATA_W-1:0] y_mac;
   logic signed [DATA_W-1:0] y_s2;

   assign coef_next = (coef_i > COEF_ONE) ? COEF_ONE : coef_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         coef_reg <= COEF_RST;
      else if (coef_we_i)
         coef_reg <= coef_next;
   end

   // S1: read state, bypassing the memory when S2 is about to write the same channel.
   always_comb begin
      chan_ok   = int'(chan_i) < CHANNELS;
      fwd_hit   = s1_reg.valid && (s1_reg.chan == REC_CH_W'(chan_i));
      yp_rd     = fwd_hit ? y_s2 : state_reg[chan_i];
      diff_next = (DATA_W+1)'(data_i) - (DATA_W+1)'(yp_rd);

      s1_next        = '0;
      s1_next.valid  = valid_i && chan_ok;
      s1_next.chan   = REC_CH_W'(chan_i);
      s1_next.x      = REC_DATA_W'(data_i);
      s1_next.yp     = REC_DATA_W'(yp_rd);
      s1_next.diff   = (REC_DATA_W+1)'(diff_next);
      s1_next.coef   = REC_COEF_W'(coef_reg);
      s1_next.bypass = bypass_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         s1_reg <= '0;
      else if (clear_i)
         s1_reg <= '0;
      else
         s1_reg <= s1_next;
   end

   iir_mc_mac #(
      .DATA_W    (DATA_W),
      .COEF_W    (COEF_W),
      .COEF_FRAC (COEF_FRAC)
   ) u_mac (
      .diff_i (s1_reg.diff[DATA_W:0]),
      .yp_i   (s1_reg.yp[DATA_W-1:0]),
      .coef_i (s1_reg.coef[COEF_W-1:0]),
      .y_o    (y_mac)
   );

   assign y_s2 = s1_reg.bypass ? s1_reg.x[DATA_W-1:0] : y_mac;

   // S2: commit result to the channel state and the output registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < CH_SLOTS; i++)
            state_reg[i] <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < CH_SLOTS; i++)
            state_reg[i] <= '0;
      end else if (s1_reg.valid) begin
         state_reg[s1_reg.chan[CH_W-1:0]] <= y_s2;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_o <= 1'b0;
         chan_o  <= '0;
         data_o  <= '0;
      end else if (clear_i) begin
         valid_o <= 1'b0;
      end else begin
         valid_o <= s1_reg.valid;
         if (s1_reg.valid) begin
            chan_o <= s1_reg.chan[CH_W-1:0];
            data_o <= y_s2;
         end
      end
   end

endmodule

// File: tb/tb_iir_mc.sv
// Directed and randomised stimulus for iir_mc; expected outputs go through a scoreboard queue
// and are matched against valid_o pulses, including the cycle they are due.
module tb_iir_mc;

   localparam int DATA_W    = 16;
   localparam int CHANNELS  = 4;
   localparam int COEF_W    = 16;
   localparam int COEF_FRAC = 15;
   localparam int CH_W      = 2;

   logic                     clk_i = 1'b0;
   logic                     reset_i;
   logic                     valid_i;
   logic [CH_W-1:0]          chan_i;
   logic signed [DATA_W-1:0] data_i;
   logic                     coef_we_i;
   logic [COEF_W-1:0]        coef_i;
   logic                     bypass_i;
   logic                     clear_i;
   logic                     valid_o;
   logic [CH_W-1:0]          chan_o;
   logic signed [DATA_W-1:0] data_o;

   typedef struct {
      int ch;
      int data;
      int due;
   } exp_t;

   exp_t sb_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   iir_mc #(
      .DATA_W    (DATA_W),
      .CHANNELS  (CHANNELS),
      .COEF_W    (COEF_W),
      .COEF_FRAC (COEF_FRAC)
   ) dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .valid_i   (valid_i),
      .chan_i    (chan_i),
      .data_i    (data_i),
      .coef_we_i (coef_we_i),
      .coef_i    (coef_i),
      .bypass_i  (bypass_i),
      .clear_i   (clear_i),
      .valid_o   (valid_o),
      .chan_o    (chan_o),
      .data_o    (data_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Monitor: every valid_o must match the head of the scoreboard, on its due cycle.
   always @(negedge clk_i) begin
      if (!reset_i) begin
         if (valid_o) begin
            if (sb_q.size() == 0) begin
               check("unexpected_valid", valid_o, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("latency", cyc, e.due);
               check("chan_o", chan_o, e.ch);
               check("data_o", $signed(data_o), e.data);
               $display("out ch=%0d data=%0d exp=%0d cyc=%0d", chan_o, data_o, e.data, cyc);
            end
         end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            check("missing_valid", valid_o, 1);
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic quiet();
      valid_i   = 1'b0;
      chan_i    = '0;
      data_i    = '0;
      coef_we_i = 1'b0;
      coef_i    = '0;
      bypass_i  = 1'b0;
      clear_i   = 1'b0;
   endtask

   // One clock edge of stimulus; called at a falling edge, returns at the next one.
   task automatic step(input bit v, input int ch, input int x, input bit exp_out, input int exp_y,
                       input bit cw = 1'b0, input int c = 0, input bit byp = 1'b0,
                       input bit clr = 1'b0);
      valid_i   = v;
      chan_i    = CH_W'(ch);
      data_i    = DATA_W'(x);
      coef_we_i = cw;
      coef_i    = COEF_W'(c);
      bypass_i  = byp;
      clear_i   = clr;
      if (exp_out) sb_q.push_back('{ch, exp_y, cyc + 2});
      @(negedge clk_i);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 0);
   endtask

   function automatic int model_y(input int yp, input int x, input int coef);
      longint diff, prod, delta;
      diff  = longint'(x) - longint'(yp);
      prod  = diff * longint'(coef);
      delta = (prod + 64'sd16384) >>> 15;
      return int'(longint'(yp) + delta);
   endfunction

   initial begin
      int st[CHANNELS];
      int coef_m;

      quiet();
      reset_i = 1'b1;
      repeat (2) @(negedge clk_i);
      check("reset_valid_o", valid_o, 0);
      check("reset_data_o", $signed(data_o), 0);
      check("reset_chan_o", chan_o, 0);
      reset_i = 1'b0;
      @(negedge clk_i);

      // Spaced samples on ch0
      step(1, 0, 8000, 1, 1000);
      idle(2);
      step(1, 0, 8000, 1, 1875);
      idle(2);

      // Back-to-back on ch1 exercises forwarding
      step(1, 1, -8000, 1, -1000);
      step(1, 1, -8000, 1, -1875);
      step(1, 1, -8000, 1, -2641);
      step(1, 2, 0, 1, 0);
      idle(2);

      // Coefficient load on the same edge as a sample, then clamped alpha = 1
      step(1, 3, 1234, 1, 154, 1, 40000);
      step(1, 3, 1234, 1, 1234);
      idle(2);

      // Bypass then filter from the bypassed state
      step(1, 0, -500, 1, -500, 0, 0, 1);
      step(1, 0, -500, 1, -500);
      idle(1);
      step(0, 0, 0, 0, 0, 1, 4096);
      idle(1);

      // Clear: in-flight sample and same-edge sample are both dropped
      step(1, 0, 8000, 1, 563);
      step(1, 0, 8000, 1, 1493);
      idle(1);
      step(1, 1, 500, 0, 0);
      step(1, 0, 8000, 0, 0, 0, 0, 0, 1);
      check("clear_valid_o", valid_o, 0);
      idle(2);
      step(1, 0, 8000, 1, 1000);
      step(1, 1, -8000, 1, -1000);
      idle(2);

      // Asynchronous reset while valid_o is high
      step(0, 0, 0, 0, 0, 1, 16384);
      step(1, 0, 8000, 0, 0);
      quiet();
      @(posedge clk_i);
      #2;
      check("pre_reset_valid_o", valid_o, 1);
      check("pre_reset_data_o", $signed(data_o), 4500);
      sb_q.delete();
      reset_i = 1'b1;
      #1;
      check("async_reset_valid_o", valid_o, 0);
      check("async_reset_data_o", $signed(data_o), 0);
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
      @(negedge clk_i);
      step(1, 0, 8000, 1, 1000);
      idle(2);

      // Randomised stream against the reference model, starting from cleared state
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      for (int k = 0; k < CHANNELS; k++) st[k] = 0;
      coef_m = 4096;
      for (int n = 0; n < 300; n++) begin
         bit v, cw, byp;
         int ch, x, c, y;
         v   = ($urandom_range(0, 9) < 8);
         ch  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
         x   = int'($urandom_range(0, 65535)) - 32768;
         cw  = ($urandom_range(0, 15) == 0);
         c   = int'($urandom_range(0, 40000));
         byp = ($urandom_range(0, 9) == 0);
         y   = 0;
         if (v) begin
            y = byp ? x : model_y(st[ch], x, coef_m);
            check("model_lossless", (y >= -32768 && y <= 32767), 1);
            st[ch] = y;
         end
         step(v, ch, x, v, y, cw, c, byp);
         if (cw) coef_m = (c > 32768) ? 32768 : c;
      end
      idle(3);
      check("queue_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
